// File: rtl/xmult_pkg.sv
// Shared constants, types and helpers for the xmult AXI4-Lite slave.
package xmult_pkg;

    // Register word indices (byte address bits [3:2])
    localparam logic [1:0] ADDR_OPA    = 2'd0;
    localparam logic [1:0] ADDR_OPB    = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    // CTRL/STATUS bit positions
    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_DONE  = 1;
    localparam int unsigned CTRL_BUSY  = 2;
    localparam int unsigned CTRL_IE    = 3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } xmult_state_e;

    // Merge new_val into old_val byte by byte under strb
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/xmult_seq_core.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle.
module xmult_seq_core #(
    parameter int unsigned OP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [OP_WIDTH-1:0]   a,
    input  logic [OP_WIDTH-1:0]   b,
    output logic                  busy,
    output logic                  done_pulse,
    output logic [2*OP_WIDTH-1:0] product
);
    import xmult_pkg::*;

    localparam int unsigned CntW = $clog2(OP_WIDTH + 1);

    xmult_state_e          state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2*OP_WIDTH-1:0] acc_q, acc_d;
    logic [2*OP_WIDTH-1:0] a_q, a_d;
    logic [OP_WIDTH-1:0]   b_q, b_d;
    logic [2*OP_WIDTH-1:0] product_q, product_d;

    // State, datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
        end
    end

    // Next-state and shift-add datapath; start is only honoured in idle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        product_d  = product_q;
        done_pulse = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = '0;
                    a_d[OP_WIDTH-1:0] = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = CntW'(OP_WIDTH);
                    state_d = StRun;
                end
            end
            StRun: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                product_d  = acc_q;
                done_pulse = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign product = product_q;

endmodule

// File: rtl/xmult_axil_slave.sv
// AXI4-Lite register front end for the xmult sequential multiplier.
module xmult_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned OP_WIDTH           = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);
    import xmult_pkg::*;

    logic                  awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0]           rdata_q;
    logic [OP_WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic                  ie_q, ie_d, done_q, done_d, irq_q, irq_d;
    logic                  wr_en, rd_en, start, core_busy, core_done;
    logic [1:0]            wr_idx, rd_idx;
    logic [31:0]           opa_ext, opb_ext, opa_mrg, opb_mrg, rd_mux;
    logic [2*OP_WIDTH-1:0] product;

    assign wr_idx = S_AXI_AWADDR[3:2];
    assign rd_idx = S_AXI_ARADDR[3:2];
    // READY is only high for one cycle and only while both VALIDs were up
    assign wr_en  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en  = arready_q & S_AXI_ARVALID;
    assign start  = wr_en && (wr_idx == ADDR_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_START];

    xmult_seq_core #(
        .OP_WIDTH (OP_WIDTH)
    ) u_core (
        .clk        (S_AXI_ACLK),
        .rst_n      (S_AXI_ARESETN),
        .start      (start),
        .a          (opa_q),
        .b          (opb_q),
        .busy       (core_busy),
        .done_pulse (core_done),
        .product    (product)
    );

    // Register file next state; FIN setting DONE beats any clear
    always_comb begin
        opa_ext = '0;
        opb_ext = '0;
        opa_ext[OP_WIDTH-1:0] = opa_q;
        opb_ext[OP_WIDTH-1:0] = opb_q;
        opa_mrg = apply_wstrb(opa_ext, S_AXI_WDATA, S_AXI_WSTRB);
        opb_mrg = apply_wstrb(opb_ext, S_AXI_WDATA, S_AXI_WSTRB);
        opa_d   = opa_q;
        opb_d   = opb_q;
        ie_d    = ie_q;
        done_d  = done_q;
        if (wr_en) begin
            case (wr_idx)
                ADDR_OPA: opa_d = opa_mrg[OP_WIDTH-1:0];
                ADDR_OPB: opb_d = opb_mrg[OP_WIDTH-1:0];
                ADDR_CTRL: begin
                    if (S_AXI_WSTRB[0]) begin
                        ie_d = S_AXI_WDATA[CTRL_IE];
                        if (S_AXI_WDATA[CTRL_DONE]) begin
                            done_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (start && !core_busy) begin
            done_d = 1'b0;
        end
        if (core_done) begin
            done_d = 1'b1;
        end
        irq_d = done_d & ie_d;
    end

    // Read data mux
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            ADDR_OPA:  rd_mux = opa_ext;
            ADDR_OPB:  rd_mux = opb_ext;
            ADDR_CTRL: begin
                rd_mux[CTRL_DONE] = done_q;
                rd_mux[CTRL_BUSY] = core_busy;
                rd_mux[CTRL_IE]   = ie_q;
            end
            default:   rd_mux[2*OP_WIDTH-1:0] = product;
        endcase
    end

    // Register file and interrupt flops
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            opa_q  <= '0;
            opb_q  <= '0;
            ie_q   <= 1'b0;
            done_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            ie_q   <= ie_d;
            done_q <= done_d;
            irq_q  <= irq_d;
        end
    end

    // Write channel: joint AW/W accept, B held until BREADY
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read channel: data captured on the AR handshake edge, held until RREADY
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign irq           = irq_q;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                         opa_mrg, opb_mrg};

endmodule

// File: tb/tb_xmult_axil_slave.sv
// Self-checking bench for xmult_axil_slave: table-driven register vectors,
// read scoreboard, and hand-written multi-cycle sequences.
module tb_xmult_axil_slave;

    logic        tb_ACLK    = 1'b0;
    logic        tb_ARESETN = 1'b0;
    logic [3:0]  S_AXI_AWADDR  = '0;
    logic [2:0]  S_AXI_AWPROT  = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA   = '0;
    logic [3:0]  S_AXI_WSTRB   = '0;
    logic        S_AXI_WVALID  = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY  = 1'b0;
    logic [3:0]  S_AXI_ARADDR  = '0;
    logic [2:0]  S_AXI_ARPROT  = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY  = 1'b0;
    logic        irq;

    xmult_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .OP_WIDTH           (16)
    ) dut (
        .S_AXI_ACLK    (tb_ACLK),
        .S_AXI_ARESETN (tb_ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .irq           (irq)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    int unsigned cyc = 0;
    always @(posedge tb_ACLK) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned wr_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    // AW+W handshake only; leaves the B response pending
    task automatic axi_aw(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        while (!S_AXI_AWREADY && n < 50) begin
            tick();
            n++;
        end
        check("aw_w_ready", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);
        tick();
        wr_cyc        = cyc;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
    endtask

    task automatic axi_b();
        int n = 0;
        S_AXI_BREADY = 1'b1;
        while (!S_AXI_BVALID && n < 50) begin
            tick();
            n++;
        end
        check("bvalid_bresp", {29'b0, S_AXI_BVALID, S_AXI_BRESP}, 32'h4);
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        axi_aw(addr, data, strb);
        axi_b();
    endtask

    task automatic wait_rvalid(input string name);
        int n = 0;
        logic [31:0] e;
        S_AXI_RREADY = 1'b1;
        while (!S_AXI_RVALID && n < 50) begin
            tick();
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check(name, S_AXI_RDATA, e);
        check({name, "_rresp"}, {29'b0, S_AXI_RVALID, S_AXI_RRESP}, 32'h4);
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic wait_arready();
        int n = 0;
        while (!S_AXI_ARREADY && n < 50) begin
            tick();
            n++;
        end
        check("arready", {31'b0, S_AXI_ARREADY}, 32'h1);
        tick();
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        wait_arready();
        S_AXI_ARVALID = 1'b0;
        wait_rvalid(name);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          viol;
        logic [31:0] first;

        vecs[0] = '{4'h0, 32'h0101FFFF, 4'hF, 32'h0000FFFF};
        vecs[1] = '{4'h0, 32'h0000AB00, 4'h2, 32'h0000ABFF};
        vecs[2] = '{4'h4, 32'h12345678, 4'hF, 32'h00005678};
        vecs[3] = '{4'h4, 32'h0000FF00, 4'h1, 32'h00005600};
        vecs[4] = '{4'h8, 32'h00000008, 4'hF, 32'h00000008};
        vecs[5] = '{4'h8, 32'h00000000, 4'hE, 32'h00000008};
        vecs[6] = '{4'h8, 32'h00000000, 4'h1, 32'h00000000};
        vecs[7] = '{4'hC, 32'hDEADBEEF, 4'hF, 32'h00000000};

        // Reset: interface quiet, all registers zero
        #500;
        check("reset_if", {22'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                           S_AXI_RVALID, irq, S_AXI_BRESP, S_AXI_RRESP}, 32'h0);
        check("reset_rdata", S_AXI_RDATA, 32'h0);
        @(posedge tb_ACLK);
        #1;
        tb_ARESETN = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), 32'h0, $sformatf("reset_reg%0d", a));
        end

        // Register vectors: write then read back
        for (int i = 0; i < 8; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            axi_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // 3 x 5
        axi_write(4'h0, 32'd3, 4'hF);
        axi_write(4'h4, 32'd5, 4'hF);
        axi_write(4'h8, 32'h1, 4'hF);
        axi_read(4'h8, 32'h4, "busy_3x5");
        repeat (20) tick();
        axi_read(4'h8, 32'h2, "done_3x5");
        axi_read(4'hC, 32'h0000000F, "result_3x5");

        // 0xFFFF x 0xFFFF with interrupt; DONE/irq latency from START accept
        axi_write(4'h0, 32'hFFFF, 4'hF);
        axi_write(4'h4, 32'hFFFF, 4'hF);
        axi_write(4'h8, 32'h9, 4'h1);
        check("irq_early", {31'b0, irq}, 32'h0);
        n = 0;
        while (!irq && n < 40) begin
            tick();
            n++;
        end
        check("irq_latency", cyc - wr_cyc, 32'd17);
        axi_read(4'hC, 32'hFFFE0001, "result_max");
        axi_read(4'h8, 32'hA, "status_done_ie");
        axi_write(4'h8, 32'hA, 4'h1);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        axi_read(4'h8, 32'h8, "status_cleared");

        // 7 x 9, then OPA write and second START while busy: both must not disturb the run
        axi_write(4'h0, 32'd7, 4'hF);
        axi_write(4'h4, 32'd9, 4'hF);
        axi_write(4'h8, 32'h1, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        axi_write(4'h8, 32'h1, 4'hF);
        repeat (30) tick();
        axi_read(4'hC, 32'h0000003F, "result_7x9");
        axi_read(4'h0, 32'h1, "opa_during_busy");
        axi_read(4'h8, 32'h2, "status_7x9");
        check("irq_ie_off", {31'b0, irq}, 32'h0);

        // B backpressure: second write must wait for BREADY
        axi_aw(4'h4, 32'h1111, 4'hF);
        S_AXI_AWADDR  = 4'h4;
        S_AXI_WDATA   = 32'h2222;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        viol = 0;
        repeat (10) begin
            tick();
            if (S_AXI_AWREADY || !S_AXI_BVALID || S_AXI_BRESP != 2'b00) viol++;
        end
        check("b_backpressure", 32'(viol), 32'h0);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        axi_aw(4'h4, 32'h2222, 4'hF);
        axi_b();
        axi_read(4'h4, 32'h2222, "opb_after_bp");

        // R backpressure: data held, second AR waits for RREADY
        exp_q.push_back(32'h2222);
        exp_q.push_back(32'h1);
        S_AXI_ARADDR  = 4'h4;
        S_AXI_ARVALID = 1'b1;
        wait_arready();
        S_AXI_ARADDR = 4'h0;
        first = S_AXI_RDATA;
        viol  = 0;
        repeat (10) begin
            tick();
            if (!S_AXI_RVALID || S_AXI_RDATA !== first || S_AXI_ARREADY) viol++;
        end
        check("r_backpressure", 32'(viol), 32'h0);
        check("r_first", first, exp_q.pop_front());
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        wait_arready();
        S_AXI_ARVALID = 1'b0;
        wait_rvalid("r_second");

        // Reset mid-run with a write response pending
        axi_write(4'h0, 32'hFFFF, 4'hF);
        axi_write(4'h4, 32'hFFFF, 4'hF);
        axi_write(4'h8, 32'h1, 4'hF);
        axi_aw(4'h4, 32'h5555, 4'hF);
        repeat (3) tick();
        tb_ARESETN = 1'b0;
        #1;
        check("midrun_rst_if", {26'b0, S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY,
                                S_AXI_WREADY, S_AXI_ARREADY, irq}, 32'h0);
        #50;
        @(posedge tb_ACLK);
        #1;
        tb_ARESETN = 1'b1;
        tick();
        axi_read(4'h8, 32'h0, "rst_status_idle");
        axi_read(4'hC, 32'h0, "rst_result");
        axi_read(4'h4, 32'h0, "rst_opb");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
